mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

RV32M front-end controller that sits directly upstream of the unsigned iterative multiply/divide core (`multDiv`). It accepts M-extension requests from the EX stage, handles signedness and RISC-V special cases, sequences the core through its single-pulse valid/ready handshake, and returns a sign-corrected 32-bit result. It also stalls the pipeline while an operation is in flight.

## Interface
- No parameters; data width fixed at 32 bits.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request strobe from EX; sampled only in IDLE or DONE
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  32  operand A (multiplicand/dividend)
- rs2  in  32  operand B (multiplier/divisor)
- kill  in  1  pipeline flush; discards the in-flight operation
- busy  out  1  stall request to pipeline
- done  out  1  one-cycle result-valid pulse
- result  out  32  final rd value; holds until the next done
- core_valid  out  1  one-cycle start pulse to core
- core_mode  out  1  0 multu, 1 divu
- core_a  out  32  unsigned magnitude of A
- core_b  out  32  unsigned magnitude of B
- core_ready  in  1  one-cycle completion pulse from core
- core_out  in  64  mult: product[63:0]; divu: {remainder, quotient}

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- On accept (req=1 in IDLE/DONE, kill=0), register funct3, sa/sb, and |A|/|B|. Both DONE and IDLE accept, so back-to-back operations are allowed.
- Operand signedness:
  - sa = rs1[31] for MULH, MULHSU, DIV, REM.
  - sb = rs2[31] for MULH, DIV, REM.
  - Otherwise the sign is 0. MUL is treated as unsigned; the low word is identical.
  - |X| = X when its sign is 0, else two's-complement negation. |0x80000000| = 0x80000000 as unsigned.
- Special cases bypass the core. Accept goes directly to DONE, with no core_valid:
  - Divide by zero (rs2=0): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Normal path:
  - IDLE/DONE --accept--> ISSUE.
  - ISSUE drives core_valid=1 and core_mode=funct3[2]; core_a/core_b are valid. ISSUE -> WAIT.
  - WAIT: on core_ready, compute and register result, then go to DONE.
- Result correction:
  - Multiply: P = core_out, negated as 64-bit if sa^sb. MUL -> P[31:0]; MULH/MULHSU/MULHU -> P[63:32].
  - DIV(U): q = core_out[31:0], negated if sa^sb.
  - REM(U): r = core_out[63:32], negated if sa.
- DONE: done=1 for one cycle, then go to IDLE (or to ISSUE/DONE on a new accept).
- Kill:
  - In ISSUE or WAIT: go to DRAIN, since the core cannot be aborted. core_valid still fires if kill arrives in the ISSUE cycle.
  - DRAIN waits for core_ready, discards core_out, asserts no done, then goes to IDLE.
  - In IDLE: blocks an accept in the same cycle.
  - In DONE: done and result are unaffected (the instruction already completed); a req in the same cycle is ignored.
- req outside IDLE/DONE is ignored. Upstream holds the request while busy.

## Timing
- Reset values: state IDLE; busy, done, core_valid, core_mode = 0; result, core_a, core_b = 0.
- busy = 1 in ISSUE, WAIT, DRAIN; 0 in IDLE and DONE. busy is a registered state decode, with no combinational path from req.
- With req accepted at cycle T:
  - ISSUE at T+1.
  - core_ready arrives N cycles after core_valid. With the core's fixed N=33, core_ready is at T+34.
  - done and result are valid at T+35.
  - The controller tolerates any N≥1.
- Bypass latency: done at T+1.
- core_out is sampled only in the core_ready cycle. core_a/core_b/core_mode are held stable from ISSUE until core_ready.
- Reset asserted mid-operation returns the block to IDLE immediately. The core is reset from the same rst_n.

## Test plan
- MULH rs1=0xFFFFFFFF(-1), rs2=0x00000002 -> core_a=1, core_b=2, core_mode=0; result=0xFFFFFFFF at T+35 with a behavioral core model.
- DIV rs1=0xFFFFFFF9(-7), rs2=2 -> core_mode=1; result=0xFFFFFFFD(-3). REM on the same operands -> 0xFFFFFFFF(-1).
- DIVU rs1=0x1234, rs2=0 -> no core_valid, done at T+1, result=0xFFFFFFFF. REM with rs1=0x80000000, rs2=0xFFFFFFFF -> result=0.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> result=0xFFFFFFFE. An immediate MUL req in the DONE cycle -> accepted, ISSUE next cycle, MUL result=0x00000001.
- kill asserted 5 cycles into WAIT for DIV -> busy stays 1 until core_ready, no done pulse, result unchanged. A req during DRAIN is ignored.
- rst_n pulsed low in WAIT -> busy/done/core_valid=0 immediately. A post-reset MULHSU rs1=0xFFFFFFFE(-2), rs2=3 -> result=0xFFFFFFFF.

Source files
------------

// File: rtl/mdu_ctrl.sv
// RV32M front-end for the unsigned iterative multDiv core: sign handling,
// divide special cases, core handshake sequencing and result correction.
//
// state | meaning
// IDLE  | waiting for a request
// ISSUE | core_valid pulse, operands presented to the core
// WAIT  | waiting for core_ready
// DRAIN | killed op still running in the core; result will be discarded
// DONE  | done pulse, result valid; may accept the next request
module mdu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        kill,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        core_valid,
    output logic        core_mode,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    input  logic        core_ready,
    input  logic [63:0] core_out
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t      state, state_nx;
    logic [2:0]  f3_q;
    logic        sa_q, sb_q;
    logic        accept, sign_a, sign_b, div_zero, div_ovf, bypass;
    logic [31:0] mag_a, mag_b, bypass_res, core_res, quo, rem;
    logic [63:0] prod;

    assign accept = (state == S_IDLE || state == S_DONE) && req && !kill;

    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin
                sign_a = rs1[31];
                sign_b = rs2[31];
            end
            3'b010:  sign_a = rs1[31];
            default: ;
        endcase
    end

    assign mag_a    = sign_a ? (32'd0 - rs1) : rs1;
    assign mag_b    = sign_b ? (32'd0 - rs2) : rs2;
    assign div_zero = funct3[2] && (rs2 == 32'd0);
    // Only the signed divide ops can overflow; DIVU/REMU of these operands is ordinary.
    assign div_ovf  = funct3[2] && !funct3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    assign bypass   = div_zero || div_ovf;

    always_comb begin
        if (div_zero)
            bypass_res = funct3[1] ? rs1 : 32'hFFFF_FFFF;
        else
            bypass_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    always_comb begin
        prod = (sa_q ^ sb_q) ? (64'd0 - core_out) : core_out;
        quo  = (sa_q ^ sb_q) ? (32'd0 - core_out[31:0]) : core_out[31:0];
        rem  = sa_q ? (32'd0 - core_out[63:32]) : core_out[63:32];
        if (!f3_q[2])
            core_res = (f3_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
        else
            core_res = f3_q[1] ? rem : quo;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept)
                    state_nx = bypass ? S_DONE : S_ISSUE;
                else
                    state_nx = S_IDLE;
            end
            S_ISSUE: state_nx = kill ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                // A kill coinciding with core_ready has nothing left to drain.
                if (kill)
                    state_nx = core_ready ? S_IDLE : S_DRAIN;
                else if (core_ready)
                    state_nx = S_DONE;
            end
            S_DRAIN: if (core_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q      <= 3'd0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            core_a    <= 32'd0;
            core_b    <= 32'd0;
            core_mode <= 1'b0;
            result    <= 32'd0;
        end else if (accept) begin
            f3_q <= funct3;
            sa_q <= sign_a;
            sb_q <= sign_b;
            if (bypass) begin
                result <= bypass_res;
            end else begin
                core_a    <= mag_a;
                core_b    <= mag_b;
                core_mode <= funct3[2];
            end
        end else if (state == S_WAIT && core_ready && !kill) begin
            result <= core_res;
        end
    end

    assign busy       = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DRAIN);
    assign done       = (state == S_DONE);
    assign core_valid = (state == S_ISSUE);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with a behavioural 33-cycle multDiv core model.
module tb_mdu_ctrl;
    localparam int CORE_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, kill;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic        busy, done, core_valid, core_mode;
    logic [31:0] result, core_a, core_b;
    logic        core_ready;
    logic [63:0] core_out;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    int t0, d0, v0;

    mdu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .kill(kill), .busy(busy), .done(done), .result(result),
        .core_valid(core_valid), .core_mode(core_mode), .core_a(core_a), .core_b(core_b),
        .core_ready(core_ready), .core_out(core_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_cnt++;
        if (done) done_cnt++;
        if (core_valid) valid_cnt++;
    end

    // Behavioural unsigned core: core_ready CORE_LAT cycles after core_valid.
    logic [31:0] m_a, m_b;
    logic        m_mode;
    int          m_cnt;

    function automatic logic [63:0] core_calc(input logic [31:0] a, input logic [31:0] b, input logic mode);
        if (!mode) return 64'(a) * 64'(b);
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ready <= 1'b0;
            core_out   <= 64'd0;
            m_cnt      <= 0;
        end else begin
            core_ready <= 1'b0;
            if (core_valid) begin
                m_a    <= core_a;
                m_b    <= core_b;
                m_mode <= core_mode;
                m_cnt  <= CORE_LAT - 1;
            end else if (m_cnt > 0) begin
                if (m_cnt == 1) begin
                    core_ready <= 1'b1;
                    core_out   <= core_calc(m_a, m_b, m_mode);
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns in the cycle after acceptance.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        t0     = cyc_cnt;
        req    = 1'b1;
        funct3 = f;
        rs1    = a;
        rs2    = b;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        while (!done && (cyc_cnt - t0) < 100) tick();
        lat = cyc_cnt - t0;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; req = 1'b0; kill = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", core_valid, 0);
        chk("rst_mode", core_mode, 0);
        chk("rst_result", result, 0);
        chk("rst_core_a", core_a, 0);
        chk("rst_core_b", core_b, 0);
        rst_n = 1'b1;
        tick();

        // MULH -1 * 2
        start_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("mulh_valid", core_valid, 1);
        chk("mulh_busy", busy, 1);
        chk("mulh_core_a", core_a, 32'd1);
        chk("mulh_core_b", core_b, 32'd2);
        chk("mulh_mode", core_mode, 0);
        wait_done(lat);
        chk("mulh_lat", lat, 35);
        chk("mulh_result", result, 32'hFFFF_FFFF);
        tick();
        chk("mulh_done_pulse", done, 0);
        chk("mulh_idle_busy", busy, 0);

        // DIV -7 / 2 and REM -7 % 2
        start_op(3'b100, 32'hFFFF_FFF9, 32'd2);
        chk("div_mode", core_mode, 1);
        chk("div_core_a", core_a, 32'd7);
        wait_done(lat);
        chk("div_lat", lat, 35);
        chk("div_result", result, 32'hFFFF_FFFD);
        tick();
        start_op(3'b110, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        chk("rem_result", result, 32'hFFFF_FFFF);
        tick();

        // Kill in IDLE blocks the accept
        kill = 1'b1; req = 1'b1; funct3 = 3'b101; rs1 = 32'h1234; rs2 = 32'd0;
        tick();
        kill = 1'b0; req = 1'b0;
        chk("kill_idle_done", done, 0);
        chk("kill_idle_busy", busy, 0);

        // Bypass: DIVU by zero, then signed-overflow REM back to back
        v0 = valid_cnt;
        start_op(3'b101, 32'h0000_1234, 32'd0);
        chk("divu0_done", done, 1);
        chk("divu0_result", result, 32'hFFFF_FFFF);
        chk("divu0_busy", busy, 0);
        start_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("removf_done", done, 1);
        chk("removf_result", result, 32'd0);
        tick();
        chk("bypass_no_valid", valid_cnt, v0);

        // MULHU max*max, then MUL accepted in the DONE cycle
        start_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        chk("mulhu_lat", lat, 35);
        chk("mulhu_result", result, 32'hFFFF_FFFE);
        start_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("b2b_valid", core_valid, 1);
        chk("b2b_busy", busy, 1);
        wait_done(lat);
        chk("mul_lat", lat, 35);
        chk("mul_result", result, 32'h0000_0001);
        tick();

        // Kill 5 cycles into WAIT; req during DRAIN ignored
        d0 = done_cnt;
        v0 = valid_cnt;
        start_op(3'b100, 32'd100, 32'd7);
        repeat (6) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("drain_busy", busy, 1);
        req = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd3;
        tick();
        req = 1'b0;
        while (busy && (cyc_cnt - t0) < 100) tick();
        chk("drain_release", cyc_cnt - t0, 35);
        repeat (3) tick();
        chk("drain_no_done", done_cnt, d0);
        chk("drain_one_valid", valid_cnt, v0 + 1);
        chk("drain_result_kept", result, 32'h0000_0001);

        // Reset pulsed mid-WAIT
        start_op(3'b101, 32'd1000, 32'd3);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_valid", core_valid, 0);
        chk("midrst_result", result, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // MULHSU -2 * 3
        start_op(3'b010, 32'hFFFF_FFFE, 32'd3);
        chk("mulhsu_core_a", core_a, 32'd2);
        chk("mulhsu_core_b", core_b, 32'd3);
        wait_done(lat);
        chk("mulhsu_lat", lat, 35);
        chk("mulhsu_result", result, 32'hFFFF_FFFF);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
